// File: rtl/expu_stream_ctrl.sv
// Valid/ready stream wrapper around an enable-driven expu_row:
// per-stage enables with bubble collapsing and a 2-entry result buffer.
module expu_stream_ctrl #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned NUM_REGS  = 2,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic                 in_valid_i,
  input  logic                 in_last_i,
  output logic                 in_ready_o,
  output logic [NUM_REGS-1:0]  row_enable_o,
  output logic                 row_clear_o,
  input  logic [WIDTH-1:0]     row_res_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [WIDTH-1:0]     out_data_o,
  output logic                 out_last_o,
  output logic                 done_o,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 busy_o
);

  if (NUM_REGS < 1) begin : g_bad_num_regs
    $error("expu_stream_ctrl: NUM_REGS must be >= 1");
  end

  logic [NUM_REGS-1:0]  v_q, v_d;
  logic [NUM_REGS-1:0]  last_q, last_d;
  logic [NUM_REGS:0]    rdy;

  logic [WIDTH-1:0]     buf_data_q [2];
  logic [WIDTH-1:0]     buf_data_d [2];
  logic [1:0]           buf_last_q, buf_last_d;
  logic [1:0]           buf_cnt_q, buf_cnt_d;
  logic                 wr_ptr_q, wr_ptr_d;
  logic                 rd_ptr_q, rd_ptr_d;

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 done_q, done_d;

  logic                 push;
  logic                 pop;

  // Ready only looks at the registered buffer count, so out_ready_i
  // never reaches the input side combinationally.
  always_comb begin
    rdy = '0;
    rdy[NUM_REGS] = (buf_cnt_q < 2'd2);
    for (int k = int'(NUM_REGS) - 1; k >= 0; k--) begin
      rdy[k] = ~v_q[k] | rdy[k+1];
    end
  end

  assign row_enable_o = rdy[NUM_REGS-1:0] & {NUM_REGS{~clear_i}};
  assign in_ready_o   = rdy[0] & ~clear_i;
  assign row_clear_o  = clear_i;

  assign push = v_q[NUM_REGS-1] & rdy[NUM_REGS] & ~clear_i;

  assign out_valid_o = (buf_cnt_q != 2'd0) & ~clear_i;
  assign pop         = out_valid_o & out_ready_i;
  assign out_data_o  = buf_data_q[rd_ptr_q];
  assign out_last_o  = buf_last_q[rd_ptr_q];

  assign done_o = done_q;
  assign cnt_o  = cnt_q;
  assign busy_o = (|v_q) | (buf_cnt_q != 2'd0);

  always_comb begin
    v_d    = v_q;
    last_d = last_q;
    if (row_enable_o[0]) begin
      v_d[0]    = in_valid_i;
      last_d[0] = in_valid_i & in_last_i;
    end
    for (int k = 1; k < int'(NUM_REGS); k++) begin
      if (row_enable_o[k]) begin
        v_d[k]    = v_q[k-1];
        last_d[k] = last_q[k-1];
      end
    end
    if (clear_i) begin
      v_d    = '0;
      last_d = '0;
    end
  end

  always_comb begin
    buf_data_d = buf_data_q;
    buf_last_d = buf_last_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (push) begin
      buf_data_d[wr_ptr_q] = row_res_i;
      buf_last_d[wr_ptr_q] = last_q[NUM_REGS-1];
      wr_ptr_d             = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    buf_cnt_d = buf_cnt_q + 2'(push) - 2'(pop);
    cnt_d     = cnt_q + CNT_WIDTH'(pop);
    done_d    = pop & out_last_o;
    if (clear_i) begin
      buf_data_d = '{default: '0};
      buf_last_d = '0;
      wr_ptr_d   = 1'b0;
      rd_ptr_d   = 1'b0;
      buf_cnt_d  = '0;
      cnt_d      = '0;
      done_d     = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v_q        <= '0;
      last_q     <= '0;
      buf_data_q <= '{default: '0};
      buf_last_q <= '0;
      buf_cnt_q  <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      v_q        <= v_d;
      last_q     <= last_d;
      buf_data_q <= buf_data_d;
      buf_last_q <= buf_last_d;
      buf_cnt_q  <= buf_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_expu_stream_ctrl.sv
// Bench for expu_stream_ctrl: behavioural row stubs, queue scoreboard,
// latency, back-pressure, clear and async reset scenarios.
module tb_expu_stream_ctrl;
  localparam int W  = 16;
  localparam int CW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  int checks = 0;
  int passed = 0;

  function automatic logic [W-1:0] golden(input logic [W-1:0] x);
    return (x * 16'd3) ^ 16'h1234;
  endfunction

  logic          a_clr, a_iv, a_il, a_ir, a_rclr, a_ov, a_or, a_ol;
  logic          a_done, a_busy;
  logic [1:0]    a_en;
  logic [W-1:0]  a_op, a_res, a_od;
  logic [CW-1:0] a_cnt;

  logic          b_clr, b_iv, b_il, b_ir, b_rclr, b_ov, b_or, b_ol;
  logic          b_done, b_busy;
  logic [2:0]    b_en;
  logic [W-1:0]  b_op, b_res, b_od;
  logic [CW-1:0] b_cnt;

  expu_stream_ctrl #(.WIDTH(W), .NUM_REGS(2), .CNT_WIDTH(CW)) u_a (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(a_clr),
    .in_valid_i(a_iv), .in_last_i(a_il), .in_ready_o(a_ir),
    .row_enable_o(a_en), .row_clear_o(a_rclr), .row_res_i(a_res),
    .out_valid_o(a_ov), .out_ready_i(a_or), .out_data_o(a_od),
    .out_last_o(a_ol), .done_o(a_done), .cnt_o(a_cnt), .busy_o(a_busy)
  );

  expu_stream_ctrl #(.WIDTH(W), .NUM_REGS(3), .CNT_WIDTH(CW)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(b_clr),
    .in_valid_i(b_iv), .in_last_i(b_il), .in_ready_o(b_ir),
    .row_enable_o(b_en), .row_clear_o(b_rclr), .row_res_i(b_res),
    .out_valid_o(b_ov), .out_ready_i(b_or), .out_data_o(b_od),
    .out_last_o(b_ol), .done_o(b_done), .cnt_o(b_cnt), .busy_o(b_busy)
  );

  // Stand-in rows: enable-gated register chain, function on the tail.
  logic [W-1:0] a_r0, a_r1;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r0 <= '0; a_r1 <= '0;
    end else if (a_rclr) begin
      a_r0 <= '0; a_r1 <= '0;
    end else begin
      if (a_en[0]) a_r0 <= a_op;
      if (a_en[1]) a_r1 <= a_r0;
    end
  end
  assign a_res = golden(a_r1);

  logic [W-1:0] b_r0, b_r1, b_r2;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_r0 <= '0; b_r1 <= '0; b_r2 <= '0;
    end else if (b_rclr) begin
      b_r0 <= '0; b_r1 <= '0; b_r2 <= '0;
    end else begin
      if (b_en[0]) b_r0 <= b_op;
      if (b_en[1]) b_r1 <= b_r0;
      if (b_en[2]) b_r2 <= b_r1;
    end
  end
  assign b_res = golden(b_r2);

  typedef struct packed {
    logic [W-1:0] d;
    logic         l;
  } item_t;

  item_t exp_q[$];
  item_t got_q[$];
  int    done_cnt = 0;
  int    last_cnt = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (a_iv && a_ir) begin
        exp_q.push_back(item_t'{d: golden(a_op), l: a_il});
        if (a_il) last_cnt++;
      end
      if (a_ov && a_or) got_q.push_back(item_t'{d: a_od, l: a_ol});
      if (a_done) done_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_clr = 0; a_iv = 0; a_il = 0; a_op = '0; a_or = 0;
    b_clr = 0; b_iv = 0; b_il = 0; b_op = '0; b_or = 0;
  endtask

  task automatic reset_dut();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    exp_q.delete(); got_q.delete();
    done_cnt = 0; last_cnt = 0;
  endtask

  task automatic single_latency(input string tag);
    logic [W-1:0] x;
    x = W'($urandom);
    a_or = 1; a_iv = 1; a_il = 1; a_op = x;
    for (int c = 0; c < 6; c++) begin
      #1;
      checks++;
      if (a_ov !== (c == 3))
        $display("FAIL %s_valid c%0d: got %b want %b", tag, c, a_ov, c == 3);
      else passed++;
      if (c == 3) begin
        checks++;
        if (a_od !== golden(x) || a_ol !== 1'b1)
          $display("FAIL %s_data: got %h/%b want %h/1", tag, a_od, a_ol, golden(x));
        else passed++;
      end
      checks++;
      if (a_done !== (c == 4))
        $display("FAIL %s_done c%0d: got %b want %b", tag, c, a_done, c == 4);
      else passed++;
      tick();
      a_iv = 0; a_il = 0;
    end
    checks++;
    if (a_cnt !== 16'd1)
      $display("FAIL %s_cnt: got %0d want 1", tag, a_cnt);
    else passed++;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    a_clr = 1;
    #1;
    checks++;
    if (a_rclr !== 1'b1 || a_ir !== 1'b0 || a_en !== 2'b00)
      $display("FAIL reset_clear_fwd: got rclr=%b ir=%b en=%b want 1 0 00",
               a_rclr, a_ir, a_en);
    else passed++;
    a_clr = 0;
    #1;
    checks++;
    if (a_rclr !== 1'b0) $display("FAIL reset_rclr: got %b want 0", a_rclr);
    else passed++;
    checks++;
    if (a_ir !== 1'b1 || a_en !== 2'b11)
      $display("FAIL reset_ready: got ir=%b en=%b want 1 11", a_ir, a_en);
    else passed++;
    checks++;
    if (a_ov !== 1'b0 || a_od !== '0 || a_ol !== 1'b0)
      $display("FAIL reset_out: got v=%b d=%h l=%b want 0 0 0", a_ov, a_od, a_ol);
    else passed++;
    checks++;
    if (a_done !== 1'b0 || a_cnt !== '0 || a_busy !== 1'b0)
      $display("FAIL reset_status: got done=%b cnt=%0d busy=%b want 0 0 0",
               a_done, a_cnt, a_busy);
    else passed++;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    reset_dut();
    single_latency("single");
  endtask

  task automatic test_throughput();
    logic [W-1:0] ops [64];
    bit           exp_v;
    reset_dut();
    for (int i = 0; i < 64; i++) ops[i] = W'($urandom);
    b_or = 1;
    for (int c = 0; c < 72; c++) begin
      b_iv = (c < 64);
      b_op = (c < 64) ? ops[c] : '0;
      b_il = (c == 63);
      #1;
      if (c < 64) begin
        checks++;
        if (b_ir !== 1'b1) $display("FAIL tput_ready c%0d: got %b want 1", c, b_ir);
        else passed++;
      end
      exp_v = (c >= 4 && c <= 67);
      checks++;
      if (b_ov !== exp_v)
        $display("FAIL tput_valid c%0d: got %b want %b", c, b_ov, exp_v);
      else passed++;
      if (exp_v) begin
        checks++;
        if (b_od !== golden(ops[c-4]) || b_ol !== (c == 67))
          $display("FAIL tput_data c%0d: got %h/%b want %h/%b",
                   c, b_od, b_ol, golden(ops[c-4]), c == 67);
        else passed++;
      end
      tick();
    end
    checks++;
    if (b_cnt !== 16'd64) $display("FAIL tput_cnt: got %0d want 64", b_cnt);
    else passed++;
  endtask

  task automatic test_backpressure();
    logic hs;
    reset_dut();
    a_or = 0; a_iv = 1; a_il = 0; a_op = W'($urandom);
    for (int c = 0; c < 10; c++) begin
      #1;
      hs = a_ir;
      tick();
      if (hs) begin
        a_op = W'($urandom);
        a_il = ($urandom_range(0, 1) == 1);
      end
    end
    #1;
    checks++;
    if (exp_q.size() != 4)
      $display("FAIL bp_accepted: got %0d want 4", exp_q.size());
    else passed++;
    checks++;
    if (a_ir !== 1'b0 || a_en !== 2'b00)
      $display("FAIL bp_stall: got ir=%b en=%b want 0 00", a_ir, a_en);
    else passed++;
    a_iv = 0; a_or = 1;
    for (int c = 0; c < 20 && got_q.size() < 4; c++) tick();
    repeat (5) tick();
    checks++;
    if (got_q.size() != 4)
      $display("FAIL bp_drain_count: got %0d want 4", got_q.size());
    else passed++;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= got_q.size() || i >= exp_q.size() || got_q[i] !== exp_q[i])
        $display("FAIL bp_order[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
      else passed++;
    end
  endtask

  task automatic test_random();
    int   n;
    int   acc;
    int   bad;
    int   first_bad;
    logic hs;
    n = 10000; acc = 0; hs = 0;
    reset_dut();
    for (int cyc = 0; cyc < 60000 && acc < n; cyc++) begin
      if (!a_iv || hs) begin
        a_iv = ($urandom_range(0, 3) != 0);
        a_op = W'($urandom);
        a_il = ($urandom_range(0, 7) == 0);
      end
      a_or = ($urandom_range(0, 2) != 0);
      #1;
      hs = a_iv && a_ir;
      if (hs) acc++;
      tick();
    end
    a_iv = 0; a_or = 1;
    checks++;
    if (acc != n) $display("FAIL rand_accept_timeout: got %0d want %0d", acc, n);
    else passed++;
    for (int c = 0; c < 100 && got_q.size() < n; c++) tick();
    repeat (3) tick();
    #1;
    checks++;
    if (got_q.size() != n || exp_q.size() != n)
      $display("FAIL rand_count: got %0d/%0d want %0d", got_q.size(), exp_q.size(), n);
    else passed++;
    bad = 0; first_bad = -1;
    for (int i = 0; i < n && i < got_q.size() && i < exp_q.size(); i++) begin
      if (got_q[i] !== exp_q[i]) begin
        bad++;
        if (first_bad < 0) first_bad = i;
      end
    end
    checks++;
    if (bad != 0)
      $display("FAIL rand_order: got %0d bad (first %0d) want 0", bad, first_bad);
    else passed++;
    checks++;
    if (done_cnt != last_cnt)
      $display("FAIL rand_done: got %0d want %0d", done_cnt, last_cnt);
    else passed++;
    checks++;
    if (a_busy !== 1'b0) $display("FAIL rand_busy: got %b want 0", a_busy);
    else passed++;
    checks++;
    if (a_cnt !== CW'(n)) $display("FAIL rand_cnt: got %0d want %0d", a_cnt, n);
    else passed++;
  endtask

  task automatic test_clear();
    logic [W-1:0] x;
    reset_dut();
    a_or = 0; a_iv = 1;
    for (int c = 0; c < 3; c++) begin
      a_op = W'($urandom); a_il = 0;
      tick();
    end
    x = W'($urandom);
    a_op = x; a_il = 1; a_clr = 1;
    #1;
    checks++;
    if (a_ir !== 1'b0 || a_ov !== 1'b0)
      $display("FAIL clr_cycle: got ir=%b ov=%b want 0 0", a_ir, a_ov);
    else passed++;
    checks++;
    if (a_rclr !== 1'b1 || a_en !== 2'b00 || a_busy !== 1'b1)
      $display("FAIL clr_row: got rclr=%b en=%b busy=%b want 1 00 1",
               a_rclr, a_en, a_busy);
    else passed++;
    tick();
    a_clr = 0; a_or = 1;
    exp_q.delete(); got_q.delete();
    for (int c = 0; c < 6; c++) begin
      #1;
      if (c == 0) begin
        checks++;
        if (a_busy !== 1'b0 || a_cnt !== '0 || a_ir !== 1'b1)
          $display("FAIL clr_after: got busy=%b cnt=%0d ir=%b want 0 0 1",
                   a_busy, a_cnt, a_ir);
        else passed++;
      end
      checks++;
      if (a_ov !== (c == 3))
        $display("FAIL clr_valid c%0d: got %b want %b", c, a_ov, c == 3);
      else passed++;
      if (c == 3) begin
        checks++;
        if (a_od !== golden(x) || a_ol !== 1'b1)
          $display("FAIL clr_data: got %h/%b want %h/1", a_od, a_ol, golden(x));
        else passed++;
      end
      tick();
      a_iv = 0; a_il = 0;
    end
    checks++;
    if (got_q.size() != 1) $display("FAIL clr_outputs: got %0d want 1", got_q.size());
    else passed++;
  endtask

  task automatic test_async_reset();
    reset_dut();
    a_or = 0; a_iv = 1; a_il = 0;
    repeat (8) begin
      a_op = W'($urandom);
      tick();
    end
    #1;
    checks++;
    if (a_ov !== 1'b1 || a_busy !== 1'b1 || a_ir !== 1'b0)
      $display("FAIL arst_pre: got ov=%b busy=%b ir=%b want 1 1 0", a_ov, a_busy, a_ir);
    else passed++;
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (a_ir !== 1'b1 || a_en !== 2'b11)
      $display("FAIL arst_ready: got ir=%b en=%b want 1 11", a_ir, a_en);
    else passed++;
    checks++;
    if (a_ov !== 1'b0 || a_od !== '0 || a_ol !== 1'b0)
      $display("FAIL arst_out: got v=%b d=%h l=%b want 0 0 0", a_ov, a_od, a_ol);
    else passed++;
    checks++;
    if (a_done !== 1'b0 || a_cnt !== '0 || a_busy !== 1'b0)
      $display("FAIL arst_status: got done=%b cnt=%0d busy=%b want 0 0 0",
               a_done, a_cnt, a_busy);
    else passed++;
    tick();
    rst_n = 1'b1; a_iv = 0;
    exp_q.delete(); got_q.delete(); done_cnt = 0; last_cnt = 0;
    tick();
    single_latency("arst");
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_single();
    test_throughput();
    test_backpressure();
    test_random();
    test_clear();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
